// File: rtl/rv_iommu_reg2apb_pkg.sv
// Shared types and constants for the regbus-to-APB4 initiator bridge.
// Optional ACCESS timeout is enabled by RV_IOMMU_REG2APB_TIMEOUT_EN.
package rv_iommu_reg2apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    localparam int unsigned APB_ADDR_W      = 32;
    localparam int unsigned APB_DATA_W      = 32;
    localparam int unsigned APB_STRB_W      = 4;
    localparam int unsigned TIMEOUT_DEFAULT = 256;

    typedef struct packed {
        logic [APB_ADDR_W-1:0] addr;
        logic                  write;
        logic [APB_DATA_W-1:0] wdata;
        logic [APB_STRB_W-1:0] wstrb;
        logic                  valid;
    } reg2apb_req_t;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  error;
        logic                  ready;
    } reg2apb_rsp_t;

endpackage

// File: rtl/rv_iommu_reg_to_apb.sv
// Regbus to APB4 initiator bridge: one request at a time, one APB transfer.
// Define RV_IOMMU_REG2APB_TIMEOUT_EN to abort stalled ACCESS phases.
module rv_iommu_reg_to_apb
    import rv_iommu_reg2apb_pkg::*;
#(
    parameter type         reg_req_t      = reg2apb_req_t,
    parameter type         reg_rsp_t      = reg2apb_rsp_t,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  reg_req_t              reg_req_i,
    output reg_rsp_t              reg_rsp_o,
    output logic [APB_ADDR_W-1:0] paddr_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [APB_DATA_W-1:0] pwdata_o,
    output logic [APB_STRB_W-1:0] pstrb_o,
    input  logic [APB_DATA_W-1:0] prdata_i,
    input  logic                  pready_i,
    input  logic                  pslverr_i
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range");
    end

    state_t                state_q, state_d;
    logic [APB_ADDR_W-1:0] addr_q;
    logic                  write_q;
    logic [APB_DATA_W-1:0] wdata_q;
    logic [APB_STRB_W-1:0] wstrb_q;
    logic [APB_DATA_W-1:0] rdata_q;
    logic                  error_q;
    logic                  expire;

`ifdef RV_IOMMU_REG2APB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q;

    // Cleared in SETUP so the count starts at zero on ACCESS entry.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (state_q == SETUP) begin
            cnt_q <= '0;
        end else if (state_q == ACCESS && !pready_i) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign expire = (state_q == ACCESS) && !pready_i && (cnt_q == TO_LAST);
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (reg_req_i.valid) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (pready_i || expire) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            if (state_q == IDLE && reg_req_i.valid) begin
                addr_q  <= reg_req_i.addr;
                write_q <= reg_req_i.write;
                wdata_q <= reg_req_i.wdata;
                wstrb_q <= reg_req_i.wstrb;
            end
            // pready beats a same-cycle timeout expiry.
            if (state_q == ACCESS && pready_i) begin
                rdata_q <= write_q ? '0 : prdata_i;
                error_q <= pslverr_i;
            end else if (expire) begin
                rdata_q <= '0;
                error_q <= 1'b1;
            end
        end
    end

    always_comb begin
        psel_o          = (state_q == SETUP) || (state_q == ACCESS);
        penable_o       = (state_q == ACCESS);
        paddr_o         = addr_q;
        pwrite_o        = write_q;
        pwdata_o        = write_q ? wdata_q : '0;
        pstrb_o         = write_q ? wstrb_q : '0;
        reg_rsp_o       = '0;
        reg_rsp_o.rdata = rdata_q;
        reg_rsp_o.error = error_q;
        reg_rsp_o.ready = (state_q == RESP);
    end

endmodule
